// File: rtl/ram_param_ctrl.sv
// rtl/ram_param_ctrl.sv - parametrised single-port RAM controller with byte enables and clear sweep
// Single-cycle req/ready access, registered readback, optional zero-fill after reset.
module ram_param_ctrl #(
  parameter int ADDR_WIDTH     = 15,
  parameter int DATA_WIDTH     = 16,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    write_enable,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    read_valid,
  output logic                    init_done
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  if ((DATA_WIDTH % 8) != 0) begin : g_width_check
    $error("DATA_WIDTH must be a multiple of 8");
  end

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clear_cnt;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic                  accept;

  assign ready     = (state == ST_RUN);
  assign init_done = (state == ST_RUN);
  assign accept    = req && ready;
  assign old_word  = mem[address];

  // Byte-lane merge; with byte_en all zero this is the old word, so a write is a no-op.
  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (byte_en[i]) merged_word[8*i +: 8] = data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      clear_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (CLEAR_ON_RESET == 0 || (&clear_cnt)) state <= ST_RUN;
      clear_cnt <= clear_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      read_valid <= accept;
      if (accept) data_out <= (write_enable && RDW_MODE != 0) ? merged_word : old_word;
    end
  end

  // Storage has no reset; accepts cannot occur while reset holds the FSM in INIT.
  always_ff @(posedge clk) begin
    if (CLEAR_ON_RESET != 0 && state == ST_INIT) begin
      mem[clear_cnt] <= '0;
    end else if (accept && write_enable) begin
      mem[address] <= merged_word;
    end
  end

endmodule

// File: tb/tb_ram_param_ctrl.sv
// tb/tb_ram_param_ctrl.sv - self-checking bench for ram_param_ctrl in both read-during-write modes
module tb_ram_param_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] din = '0;
  logic [1:0]  be = '0;

  logic        ready0, rv0, init0;
  logic [15:0] do0;
  logic        ready1, rv1, init1;
  logic [15:0] do1;

  int total = 0;
  int bad = 0;
  bit started = 0;

  always #5 clk = ~clk;

  ram_param_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .reset(reset), .req(req), .write_enable(we), .address(addr), .data(din),
    .byte_en(be), .ready(ready0), .data_out(do0), .read_valid(rv0), .init_done(init0));

  ram_param_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .write_enable(we), .address(addr), .data(din),
    .byte_en(be), .ready(ready1), .data_out(do1), .read_valid(rv1), .init_done(init1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts down the remaining sweep edges, keeps the storage as a plain array.
  int          sweep_left = 16;
  logic [15:0] mem_m [16];
  logic        rv_m = 1'b0;
  logic [15:0] q0_m = '0;
  logic [15:0] q1_m = '0;
  logic [15:0] old_m, new_m;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sweep_left = 16;
      rv_m = 1'b0;
      q0_m = '0;
      q1_m = '0;
    end else if (sweep_left > 0) begin
      mem_m[16 - sweep_left] = '0;
      sweep_left--;
      rv_m = 1'b0;
    end else begin
      rv_m = req;
      if (req) begin
        old_m = mem_m[addr];
        new_m = old_m;
        if (we) begin
          if (be[0]) new_m[7:0]  = din[7:0];
          if (be[1]) new_m[15:8] = din[15:8];
          mem_m[addr] = new_m;
        end
        q0_m = old_m;
        q1_m = we ? new_m : old_m;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("ready0", ready0, sweep_left == 0);
      check("ready1", ready1, sweep_left == 0);
      check("init0", init0, sweep_left == 0);
      check("init1", init1, sweep_left == 0);
      check("rv0", rv0, rv_m);
      check("rv1", rv1, rv_m);
      check("dout0", do0, q0_m);
      check("dout1", do1, q1_m);
    end
  end

  // Drives one access for the next edge, samples both DUTs just after it.
  task automatic acc(input logic w, input logic [3:0] a, input logic [15:0] d, input logic [1:0] b,
                     output logic [15:0] q0, output logic [15:0] q1, output logic v);
    req = 1'b1; we = w; addr = a; din = d; be = b;
    @(posedge clk); #1;
    q0 = do0; q1 = do1; v = rv0 & rv1;
  endtask

  // Counts edges from reset release until ready; optionally injects a write 3 edges in.
  task automatic sweep(input bit inject);
    int n;
    n = 0;
    while (!(ready0 && ready1) && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (inject && n == 2) begin
        req = 1'b1; we = 1'b1; addr = 4'h3; din = 16'hFFFF; be = 2'b11;
      end
      if (n == 3) req = 1'b0;
      check("sweep_rv", rv0 | rv1, 0);
    end
    check("sweep_len", n, 16);
    check("sweep_init", init0 & init1, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"}, ready0 | ready1, 0);
    check({tag, "_init"}, init0 | init1, 0);
    check({tag, "_rv"}, rv0 | rv1, 0);
    check({tag, "_dout0"}, do0, 0);
    check({tag, "_dout1"}, do1, 0);
  endtask

  logic [15:0] q0, q1;
  logic        v;

  initial begin
    #1 reset = 1'b1;
    started = 1;
    #1 check_zero_outputs("rst");
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    sweep(1'b1);

    for (int i = 0; i < 16; i++) begin
      acc(1'b0, i[3:0], 16'h0, 2'b00, q0, q1, v);
      check("clr_v", v, 1);
      check("clr_q0", q0, 16'h0000);
      check("clr_q1", q1, 16'h0000);
    end
    req = 1'b0;

    acc(1'b1, 4'hA, 16'hAAAA, 2'b11, q0, q1, v);
    check("wr1_q0", q0, 16'h0000);
    check("wr1_q1", q1, 16'hAAAA);
    acc(1'b0, 4'hA, 16'h0, 2'b00, q0, q1, v);
    check("rd1_v", v, 1);
    check("rd1_q0", q0, 16'hAAAA);
    check("rd1_q1", q1, 16'hAAAA);
    req = 1'b0;
    @(posedge clk); #1;
    check("rd1_pulse", rv0 | rv1, 0);
    check("hold_q0", do0, 16'hAAAA);

    acc(1'b1, 4'hA, 16'h5555, 2'b01, q0, q1, v);
    check("wr2_q0", q0, 16'hAAAA);
    check("wr2_q1", q1, 16'hAA55);
    acc(1'b0, 4'hA, 16'h0, 2'b00, q0, q1, v);
    check("rd2_q0", q0, 16'hAA55);
    check("rd2_q1", q1, 16'hAA55);
    acc(1'b1, 4'hA, 16'hFFFF, 2'b00, q0, q1, v);
    check("wr3_v", v, 1);
    check("wr3_q1", q1, 16'hAA55);
    acc(1'b0, 4'hA, 16'h0, 2'b00, q0, q1, v);
    check("rd3_q0", q0, 16'hAA55);

    acc(1'b1, 4'hA, 16'h1234, 2'b11, q0, q1, v);
    check("rdw_q0", q0, 16'hAA55);
    check("rdw_q1", q1, 16'h1234);
    acc(1'b0, 4'hA, 16'h0, 2'b00, q0, q1, v);
    check("rd4_q0", q0, 16'h1234);
    check("rd4_q1", q1, 16'h1234);
    req = 1'b0;

    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = 4'hA;
    #3 reset = 1'b1;
    #1 check_zero_outputs("run_rst");
    repeat (2) begin
      @(posedge clk); #1;
      check("run_rst_rv", rv0 | rv1, 0);
    end
    req = 1'b0;
    @(negedge clk) reset = 1'b0;
    sweep(1'b0);
    acc(1'b0, 4'hA, 16'h0, 2'b00, q0, q1, v);
    check("run_rst_clr", q0 | q1, 16'h0000);
    req = 1'b0;

    acc(1'b1, 4'h5, 16'hBEEF, 2'b11, q0, q1, v);
    req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_zero_outputs("mid_rst");
    @(negedge clk) reset = 1'b0;
    sweep(1'b0);
    acc(1'b0, 4'h5, 16'h0, 2'b00, q0, q1, v);
    check("mid_rst_clr", q0 | q1, 16'h0000);
    req = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_param_ctrl.md
Name: ram_param_ctrl

Overview:
- Parametrised successor to the team's single-port 15-bit-address / 16-bit-data synchronous RAM.
- Generalised in address and data width. Adds per-byte write enables, a req/ready handshake, a registered read with a read_valid strobe, and selectable read-during-write data.
- Optionally runs a hardware clear sweep after reset; init_done flags when the RAM is usable.
- Sits between a bus master and on-chip storage; single clock domain.

Parameters:
- ADDR_WIDTH, 15, address bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 16, word width; must be a multiple of 8 (elaboration error otherwise).
- RDW_MODE, 0, data returned on a write access: 0 = old word (read-first), 1 = new merged word (write-through).
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the clear, contents undefined.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  access request; accepted only on a cycle with req && ready.
- write_enable  in  1  1 = write access, 0 = read access; sampled with req.
- address  in  ADDR_WIDTH  word address.
- data  in  DATA_WIDTH  write data.
- byte_en  in  DATA_WIDTH/8  per-byte write mask; bit i covers data[8i+7:8i]; ignored on reads.
- ready  out  1  controller can accept a request this cycle.
- data_out  out  DATA_WIDTH  registered read / readback data.
- read_valid  out  1  one-cycle strobe: data_out updated this cycle.
- init_done  out  1  clear sweep complete; stays high until the next reset.

Behaviour:
- States: INIT (clear sweep), RUN.
- Reset asserted, asynchronous and immediate:
  - state = INIT, clear counter = 0.
  - ready = 0, read_valid = 0, data_out = 0, init_done = 0.
  - Memory array contents are not reset directly.
- INIT with CLEAR_ON_RESET=1:
  - On each rising edge after reset deasserts, write all-zero to mem[counter], then counter += 1.
  - After the edge that writes address 2**ADDR_WIDTH-1, go to RUN; ready and init_done go high on that same edge.
  - Total: exactly 2**ADDR_WIDTH edges with ready=0.
- INIT with CLEAR_ON_RESET=0: go to RUN on the first rising edge after reset deasserts; ready and init_done go high on that edge.
- RUN: ready = 1 every cycle (single-cycle access, no back-pressure).
- Any req while ready=0 is ignored: no write, no read_valid, no queuing.
- Read accept (req && ready && !write_enable) at edge N:
  - data_out = mem[address] registered at edge N.
  - read_valid high for the cycle following edge N only.
- Write accept (req && ready && write_enable) at edge N:
  - Every byte i with byte_en[i]=1 is updated from data; other bytes are unchanged.
  - byte_en = 0 performs no update but still produces readback.
  - Readback: data_out = old word (RDW_MODE=0) or new merged word (RDW_MODE=1), with read_valid high for one cycle as for a read.
- Back-to-back accesses, one per cycle:
  - A read of address A on the cycle after a write to A returns the written data in both modes.
  - Consecutive reads give consecutive read_valid pulses, one per accepted read.
- data_out holds its last value when no access is accepted.
- Address is used modulo depth; no out-of-range condition exists.
- Reset during INIT or RUN:
  - Any in-flight access is abandoned.
  - The clear sweep restarts from address 0.
  - With CLEAR_ON_RESET=0, memory keeps its old contents.

Test Plan (ADDR_WIDTH=4, DATA_WIDTH=16 unless noted):
- Init sweep: pulse reset, release, then read all 16 addresses.
  - Required: ready=0 and init_done=0 for exactly 16 edges, then both rise together.
  - Required: every read returns 16'h0000.
- Write then read: write addr 4'hA, data 16'hAAAA, byte_en 2'b11; read 4'hA on the next cycle.
  - Required: data_out = 16'hAAAA, with read_valid high exactly one cycle after the read accept.
- Byte mask: write addr 4'hA, data 16'h5555, byte_en 2'b01; read 4'hA.
  - Required: data_out = 16'hAA55.
  - Then write with byte_en 2'b00; required: content still 16'hAA55.
- Read-during-write: with 4'hA = 16'hAA55, write 16'h1234, byte_en 2'b11.
  - Required RDW_MODE=0: readback 16'hAA55.
  - Required RDW_MODE=1: readback 16'h1234.
  - Required, both modes: a following read returns 16'h1234.
- Ignored requests: issue a write (addr 4'h3, 16'hFFFF) 3 edges into the sweep.
  - Required: no read_valid pulse.
  - Required: after init_done, addr 4'h3 reads 16'h0000.
- Reset mid-operation: assert reset asynchronously 5 edges into the sweep, mid-cycle.
  - Required: outputs go to 0 before the next edge.
  - Required: after release, a full 16-edge sweep precedes ready.
  - Repeat in RUN with a read pending. Required: read_valid never pulses for the abandoned read.
